gated_reg_bank: RTL and testbench
=================================

GATED_REG_BANK -- requirements
Module: gated_reg_bank

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent register channels (1..16).
REQ-002 SHALL have parameter W, default 8: data width per channel (>=1).
REQ-003 SHALL have parameter IDLE_CYC, default 8: consecutive idle cycles before a channel gates (>=1).
REQ-004 SHALL have parameter WAKE_CYC, default 2: wake-up latency in cycles from GATED to RUN (>=1).
REQ-005 SHALL have port clk  input  1  clock, rising-edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port in_valid  input  CH  per-channel write request.
REQ-008 SHALL have port in_data  input  CH*W  per-channel write data, channel i at bits [i*W +: W].
REQ-009 SHALL have port force_on  input  1  global override; inhibits gating and wakes gated channels.
REQ-010 SHALL have port in_ready  output  CH  per-channel write acceptance.
REQ-011 SHALL have port q  output  CH*W  per-channel registered data, same packing as in_data.
REQ-012 SHALL have port gate_en  output  CH  per-channel clock-enable to the ICG cell (1 = clock running).
REQ-013 SHALL have port gated  output  CH  per-channel status, 1 in GATED state only.
REQ-014 SHALL have port all_gated  output  1  AND of gated[CH-1:0].

Function
REQ-015 SHALL implement per channel an FSM with states RUN, GATED, WAKE; all outputs registered or decoded from state only.
REQ-016 SHALL accept a write on channel i when in_valid[i] & in_ready[i] at a rising edge; q[i] takes in_data[i] on that edge (1-cycle latency).
REQ-017 SHALL hold q[i] unchanged whenever no write is accepted, including throughout GATED and WAKE.
REQ-018 RUN: in_ready=1, gate_en=1, gated=0; idle counter (width clog2(IDLE_CYC+1)) increments each cycle with in_valid[i]=0, clears on any accepted write.
REQ-019 RUN->GATED on the edge where idle counter==IDLE_CYC-1, in_valid[i]=0 and force_on=0, i.e. after IDLE_CYC consecutive idle cycles.
REQ-020 in_valid[i]=1 on the cycle the idle counter would expire: write accepted, counter cleared, channel stays RUN.
REQ-021 force_on=1 in RUN: idle counter held at 0, no transition to GATED.
REQ-022 GATED: in_ready=0, gate_en=0, gated=1; in_valid[i]=1 or force_on=1 -> WAKE on next edge, wake counter loaded with 0.
REQ-023 WAKE: in_ready=0, gate_en=1, gated=0; wake counter increments each cycle; -> RUN on the edge where wake counter==WAKE_CYC-1.
REQ-024 WAKE SHALL not abort if in_valid drops; channel completes wake to RUN with idle counter 0.
REQ-025 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.
REQ-026 in_data SHALL be ignored whenever in_ready[i]=0; no write is buffered across GATED/WAKE.

Reset
REQ-027 reset=1 at a rising edge SHALL force every channel to RUN with q=0, idle and wake counters 0, in_ready=all-1, gate_en=all-1, gated=0, all_gated=0.
REQ-028 reset SHALL take priority over any write or transition in the same cycle, including mid-WAKE.

Verification
REQ-029 Defaults, reset then in_valid=0 for 8 cycles -> gated=4'hF, all_gated=1, gate_en=0 on cycle 9 after reset release; q stays 0.
REQ-030 Ch0 gated, in_valid[0]=1, data 8'hA5 held -> in_ready[0]=0 for 3 cycles (1 to WAKE + 2 WAKE), then 1; q[0]=8'hA5 the cycle after acceptance.
REQ-031 Ch1 idle 7 cycles then in_valid[1]=1 data 8'h3C on 8th -> no gating, q[1]=8'h3C, gating needs 8 further idle cycles.
REQ-032 force_on=1 with all channels gated -> all enter WAKE, RUN after 2 cycles, no gating while force_on held for 20 cycles.
REQ-033 reset asserted during ch2 WAKE -> ch2 in RUN, in_ready[2]=1, q[2]=0 next cycle.
REQ-034 Ch0 and ch3 written 8'h11/8'h22 same cycle while ch1 gated -> both q updated, ch1 stays gated, all_gated=0.

Source files
------------

// File: rtl/gated_reg_bank.sv
// rtl/gated_reg_bank.sv - per-channel register bank with idle-driven clock gating
module gated_reg_bank #(
    parameter int CH       = 4,
    parameter int W        = 8,
    parameter int IDLE_CYC = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CH-1:0]   in_valid,
    input  logic [CH*W-1:0] in_data,
    input  logic            force_on,
    output logic [CH-1:0]   in_ready,
    output logic [CH*W-1:0] q,
    output logic [CH-1:0]   gate_en,
    output logic [CH-1:0]   gated,
    output logic            all_gated
);

    localparam int IW = $clog2(IDLE_CYC + 1);
    localparam int WW = $clog2(WAKE_CYC + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYC - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        GATED = 2'd1,
        WAKE  = 2'd2
    } state_t;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        state_t        state, state_nxt;
        logic [IW-1:0] idle_cnt, idle_nxt;
        logic [WW-1:0] wake_cnt, wake_nxt;
        logic [W-1:0]  q_r;
        logic          wr_en;
        logic          rdy, gen, gtd;

        always_ff @(posedge clk) begin
            if (reset) begin
                state    <= RUN;
                idle_cnt <= '0;
                wake_cnt <= '0;
                q_r      <= '0;
            end else begin
                state    <= state_nxt;
                idle_cnt <= idle_nxt;
                wake_cnt <= wake_nxt;
                if (wr_en) begin
                    q_r <= in_data[g*W +: W];
                end
            end
        end

        // A write only lands in RUN; data offered while gated or waking is dropped.
        always_comb begin
            state_nxt = state;
            idle_nxt  = idle_cnt;
            wake_nxt  = wake_cnt;
            wr_en     = 1'b0;
            case (state)
                RUN: begin
                    if (in_valid[g]) begin
                        wr_en    = 1'b1;
                        idle_nxt = '0;
                    end else if (force_on) begin
                        idle_nxt = '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        state_nxt = GATED;
                        idle_nxt  = '0;
                    end else begin
                        idle_nxt = idle_cnt + 1'b1;
                    end
                end
                GATED: begin
                    if (in_valid[g] || force_on) begin
                        state_nxt = WAKE;
                        wake_nxt  = '0;
                    end
                end
                WAKE: begin
                    if (wake_cnt == WAKE_LAST) begin
                        state_nxt = RUN;
                        idle_nxt  = '0;
                        wake_nxt  = '0;
                    end else begin
                        wake_nxt = wake_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    idle_nxt  = '0;
                    wake_nxt  = '0;
                end
            endcase
        end

        always_comb begin
            rdy = (state == RUN);
            gen = (state != GATED);
            gtd = (state == GATED);
        end

        assign in_ready[g]     = rdy;
        assign gate_en[g]      = gen;
        assign gated[g]        = gtd;
        assign q[g*W +: W]     = q_r;
    end

    assign all_gated = &gated;

endmodule

// File: tb/tb_gated_reg_bank.sv
// tb/tb_gated_reg_bank.sv - self-checking bench for gated_reg_bank
module tb_gated_reg_bank;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int IDLE_CYC = 8;
    localparam int WAKE_CYC = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [CH-1:0]   in_valid;
    logic [CH*W-1:0] in_data;
    logic            force_on;
    logic [CH-1:0]   in_ready;
    logic [CH*W-1:0] q;
    logic [CH-1:0]   gate_en;
    logic [CH-1:0]   gated;
    logic            all_gated;

    int errors = 0;
    int checks = 0;

    gated_reg_bank #(.CH(CH), .W(W), .IDLE_CYC(IDLE_CYC), .WAKE_CYC(WAKE_CYC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .force_on(force_on), .in_ready(in_ready), .q(q), .gate_en(gate_en),
        .gated(gated), .all_gated(all_gated)
    );

    always #5 clk = ~clk;

    // Reference: idle run length, remaining wake cycles, gated flag, stored word.
    int         m_idle [CH];
    int         m_wake [CH];
    bit         m_g    [CH];
    logic [W-1:0] m_q  [CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic [CH-1:0] v,
                                input logic [CH*W-1:0] d, input logic f);
        for (int c = 0; c < CH; c++) begin
            if (r) begin
                m_idle[c] = 0; m_wake[c] = 0; m_g[c] = 0; m_q[c] = '0;
            end else if (m_g[c]) begin
                if (v[c] || f) begin
                    m_g[c] = 0;
                    m_wake[c] = WAKE_CYC;
                end
            end else if (m_wake[c] > 0) begin
                m_wake[c]--;
                if (m_wake[c] == 0) m_idle[c] = 0;
            end else if (v[c]) begin
                m_q[c] = d[c*W +: W];
                m_idle[c] = 0;
            end else if (f) begin
                m_idle[c] = 0;
            end else begin
                m_idle[c]++;
                if (m_idle[c] == IDLE_CYC) begin
                    m_g[c] = 1;
                    m_idle[c] = 0;
                end
            end
        end
    endtask

    task automatic model_compare();
        logic [CH-1:0]   e_rdy, e_gen, e_gtd;
        logic [CH*W-1:0] e_q;
        for (int c = 0; c < CH; c++) begin
            e_gtd[c] = m_g[c];
            e_gen[c] = !m_g[c];
            e_rdy[c] = !m_g[c] && (m_wake[c] == 0);
            e_q[c*W +: W] = m_q[c];
        end
        chk("model_in_ready", 32'(in_ready), 32'(e_rdy));
        chk("model_gate_en", 32'(gate_en), 32'(e_gen));
        chk("model_gated", 32'(gated), 32'(e_gtd));
        chk("model_all_gated", 32'(all_gated), 32'(&e_gtd));
        chk("model_q", 32'(q), 32'(e_q));
    endtask

    task automatic step(input logic r, input logic [CH-1:0] v,
                        input logic [CH*W-1:0] d, input logic f);
        reset = r; in_valid = v; in_data = d; force_on = f;
        @(posedge clk);
        model_update(r, v, d, f);
        #1;
        model_compare();
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [31:0] dat;
        logic        frc;
        logic [3:0]  e_rdy;
        logic [3:0]  e_gen;
        logic [3:0]  e_gtd;
        logic [31:0] e_q;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [3:0] vld, logic [31:0] dat, logic frc,
                                logic [3:0] e_rdy, logic [3:0] e_gen, logic [3:0] e_gtd,
                                logic [31:0] e_q);
        vec_t v;
        v.rst = rst; v.vld = vld; v.dat = dat; v.frc = frc;
        v.e_rdy = e_rdy; v.e_gen = e_gen; v.e_gtd = e_gtd; v.e_q = e_q;
        return v;
    endfunction

    initial begin
        reset = 1'b1; in_valid = '0; in_data = '0; force_on = 1'b0;

        // Reset, gate after 8 idle cycles, then wake ch0 with a held write of A5.
        vecs.push_back(mk(1, 4'h0, 32'h0, 0, 4'hF, 4'hF, 4'h0, 32'h0));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(0, 4'h0, 32'h0, 0, 4'hF, 4'hF, 4'h0, 32'h0));
        vecs.push_back(mk(0, 4'h0, 32'h0, 0, 4'h0, 4'h0, 4'hF, 32'h0));
        vecs.push_back(mk(0, 4'h1, 32'hA5, 0, 4'h0, 4'h1, 4'hE, 32'h0));
        vecs.push_back(mk(0, 4'h1, 32'hA5, 0, 4'h0, 4'h1, 4'hE, 32'h0));
        vecs.push_back(mk(0, 4'h1, 32'hA5, 0, 4'h1, 4'h1, 4'hE, 32'h0));
        vecs.push_back(mk(0, 4'h1, 32'hA5, 0, 4'h1, 4'h1, 4'hE, 32'hA5));
        vecs.push_back(mk(0, 4'h0, 32'h0,  0, 4'h1, 4'h1, 4'hE, 32'hA5));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].vld, vecs[i].dat, vecs[i].frc);
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_gate_en", i), 32'(gate_en), 32'(vecs[i].e_gen));
            chk($sformatf("vec%0d_gated", i), 32'(gated), 32'(vecs[i].e_gtd));
            chk($sformatf("vec%0d_all_gated", i), 32'(all_gated), 32'(&vecs[i].e_gtd));
            chk($sformatf("vec%0d_q", i), q, vecs[i].e_q);
        end

        // Ch1 write on the cycle its idle counter would expire.
        step(1, 4'h0, 32'h0, 0);
        for (int i = 0; i < 7; i++) step(0, 4'h0, 32'h0, 0);
        step(0, 4'b0010, 32'h0000_3C00, 0);
        chk("late_write_gated", 32'(gated), 32'hD);
        chk("late_write_q1", 32'(q[15:8]), 32'h3C);
        for (int i = 0; i < 7; i++) step(0, 4'h0, 32'h0, 0);
        chk("late_write_still_run", 32'(gated[1]), 32'h0);
        step(0, 4'h0, 32'h0, 0);
        chk("late_write_now_gated", 32'(gated), 32'hF);
        chk("late_write_all_gated", 32'(all_gated), 32'h1);

        // force_on wakes everything and blocks gating while held.
        step(0, 4'h0, 32'h0, 1);
        chk("force_wake_gated", 32'(gated), 32'h0);
        chk("force_wake_ready", 32'(in_ready), 32'h0);
        chk("force_wake_gate_en", 32'(gate_en), 32'hF);
        step(0, 4'h0, 32'h0, 1);
        chk("force_wake_ready2", 32'(in_ready), 32'h0);
        step(0, 4'h0, 32'h0, 1);
        chk("force_run_ready", 32'(in_ready), 32'hF);
        for (int i = 0; i < 20; i++) step(0, 4'h0, 32'h0, 1);
        chk("force_hold_gated", 32'(gated), 32'h0);
        for (int i = 0; i < 8; i++) step(0, 4'h0, 32'h0, 0);
        chk("force_release_gated", 32'(gated), 32'hF);

        // Reset in the middle of a ch2 wake.
        step(1, 4'h0, 32'h0, 0);
        step(0, 4'b0100, 32'h0055_0000, 0);
        chk("mid_wake_write", q, 32'h0055_0000);
        for (int i = 0; i < 8; i++) step(0, 4'h0, 32'h0, 0);
        step(0, 4'b0100, 32'h0077_0000, 0);
        chk("mid_wake_ready2", 32'(in_ready[2]), 32'h0);
        chk("mid_wake_gate_en2", 32'(gate_en[2]), 32'h1);
        step(1, 4'h0, 32'h0, 0);
        chk("mid_wake_reset_ready", 32'(in_ready), 32'hF);
        chk("mid_wake_reset_q", q, 32'h0);

        // Simultaneous writes on ch0/ch3 with ch1 gated.
        for (int i = 0; i < 8; i++) step(0, 4'b1101, 32'h0, 0);
        chk("indep_ch1_gated", 32'(gated), 32'h2);
        step(0, 4'b1001, 32'h2200_0011, 0);
        chk("indep_q", q, 32'h2200_0011);
        chk("indep_gated", 32'(gated), 32'h2);
        chk("indep_all_gated", 32'(all_gated), 32'h0);

        // Random traffic against the reference model.
        step(1, 4'h0, 32'h0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic [CH-1:0] v;
            for (int c = 0; c < CH; c++) v[c] = ($urandom_range(0, 5) == 0);
            step($urandom_range(0, 299) == 0, v, $urandom, $urandom_range(0, 39) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
